softmax_seq_ctrl: RTL and testbench
===================================

SOFTMAX_SEQ_CTRL -- requirements
Module: softmax_seq_ctrl

Interface
REQ-001 Parameter N_MAX, default 16, is the maximum number of elements in one score vector.
REQ-002 Parameter EXP_LAT, default 1, is the number of cycles from a change on exp_x to a valid exp_y.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  score beat valid.
REQ-006 in_ready  output  1  controller accepts a score beat.
REQ-007 in_data  input  17  score, signed Q5.12 (5 integer bits including sign, 12 fraction bits).
REQ-008 in_last  input  1  final beat of the vector.
REQ-009 exp_x  output  17  operand to the exp datapath, signed Q5.12.
REQ-010 exp_y  input  21  exp datapath result, {position[4:0], mantissa[15:0]}, treated as opaque.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  downstream accepts a result beat.
REQ-013 out_data  output  21  exp result for one element, in input order.
REQ-014 out_last  output  1  final result beat of the vector.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 trunc_err  output  1  one-cycle pulse when a vector is cut at N_MAX.

Function
REQ-017 The controller SHALL implement the states IDLE, LOAD, EXP and DRAIN.
REQ-018 IDLE SHALL assert in_ready and move to LOAD on the first accepted beat, storing it at index 0 and loading max_r with it.
REQ-019 LOAD SHALL hold in_ready high and store each accepted beat (in_valid and in_ready) at the next index, with max_r = signed max(max_r, in_data).
REQ-020 LOAD SHALL end on an accepted beat with in_last=1, or on the beat at index N_MAX-1; len_r is then the element count (1..N_MAX).
REQ-021 If the beat at index N_MAX-1 has in_last=0, trunc_err SHALL pulse for 1 cycle; later beats are handled as a new vector.
REQ-022 A single-beat vector in IDLE with in_last=1 SHALL go directly to EXP.
REQ-023 in_ready SHALL be low in EXP and DRAIN.
REQ-024 EXP SHALL process index i = 0..len_r-1: drive exp_x = clamp(buf[i] - max_r), hold it EXP_LAT cycles, then capture exp_y into res[i].
REQ-025 The subtraction SHALL be 18-bit signed; a result below -10.0 (0x16000) SHALL be clamped to 0x16000, and the result is never positive.
REQ-026 exp_x SHALL be 0 outside EXP.
REQ-027 EXP SHALL take exactly len_r*(EXP_LAT+1) cycles, then enter DRAIN.
REQ-028 DRAIN SHALL present res[0..len_r-1] in order, with out_valid high, and advance only on out_valid and out_ready.
REQ-029 out_last SHALL be high together with out_valid on the beat at index len_r-1.
REQ-030 While out_ready is low, out_data and out_last SHALL stay stable.
REQ-031 After the last accepted result beat, the controller SHALL return to IDLE, with in_ready high on the next cycle.
REQ-032 Data from two vectors SHALL never mix; a new vector is accepted only in IDLE.

Reset
REQ-033 With rst=1 at a clock edge, the state SHALL become IDLE, and indices, len_r, max_r and res SHALL be cleared.
REQ-034 Output values in reset: in_ready=0 while rst is high, out_valid=0, out_last=0, busy=0, trunc_err=0, exp_x=0.
REQ-035 Reset in any state (mid-LOAD, mid-EXP, mid-DRAIN) SHALL drop the partial vector, with no further out_valid beats from it.
REQ-036 In the first cycle after rst falls, in_ready SHALL be 1.

Verification
REQ-037 Input 0x01000, 0x02000, 0x00000(last), EXP_LAT=1 -> exp_x sequence 0x1F000, 0x00000, 0x1E000, each held 2 cycles; 3 out beats, out_last on the 3rd.
REQ-038 Input 0x08000, 0x18000(last) -> exp_x 0x00000, then 0x16000 (clamped from -16.0).
REQ-039 16 beats with in_last=0 -> trunc_err pulse on beat 16, len_r=16, 16 out beats; a 17th beat with in_last=1 is a new 1-element vector, exp_x=0x00000.
REQ-040 Single beat 0x0A000(last) -> exp_x=0x00000; out_data equals the exp_y value captured; out_last=1 on that beat.
REQ-041 out_ready toggled 1,0,0,1 during DRAIN -> out_data held stable across stalls, no beats lost or duplicated.
REQ-042 rst pulsed in mid-EXP -> busy=0 and out_valid=0 the next cycle; the next vector is processed correctly.

Source files
------------

// File: rtl/softmax_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : softmax_seq_ctrl_if
//  Purpose  : Score-in / result-out streaming handshake bundle for the
//             softmax sequencing controller.
//  Revision : 1.0  initial release
// ============================================================================
interface softmax_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_data;    // signed Q5.12 score
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_data;   // opaque exp result
  logic        out_last;

  // Producer of scores / consumer of results
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The controller itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/softmax_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : softmax_seq_ctrl
//  Purpose  : Buffers one score vector while tracking its maximum, feeds
//             clamp(score - max) to an external exp unit element by element,
//             then streams the exp results out in input order.
//  Revision : 1.0  initial release
// ============================================================================
module softmax_seq_ctrl #(
  parameter int N_MAX   = 16,
  parameter int EXP_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  softmax_seq_ctrl_if.slave  bus,
  output logic [16:0]        exp_x,
  input  logic [20:0]        exp_y,
  output logic               busy,
  output logic               trunc_err
);

  localparam int IDX_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int LEN_W = $clog2(N_MAX + 1);
  localparam int CNT_W = (EXP_LAT > 0) ? $clog2(EXP_LAT + 1) : 1;
  localparam logic [IDX_W-1:0]    LAST_SLOT = IDX_W'(N_MAX - 1);
  localparam logic [CNT_W-1:0]    LAT_MAX   = CNT_W'(EXP_LAT);
  // -10.0 in Q5.12; anything more negative saturates here
  localparam logic signed [17:0]  CLAMP_MIN = -18'sd40960;
  localparam logic [16:0]         CLAMP_VAL = 17'h16000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state_r, next_state;

  logic [IDX_W-1:0]   wr_idx, exp_idx, rd_idx;
  logic [CNT_W-1:0]   lat_cnt;
  logic [LEN_W-1:0]   len_r;
  logic signed [16:0] max_r;
  logic signed [16:0] score_r [N_MAX];
  logic [20:0]        res_r   [N_MAX];
  logic               trunc_r;

  logic               in_ready_int;
  logic               accept;
  logic               at_last_slot;
  logic               load_end;
  logic               lat_done;
  logic               exp_last;
  logic               rd_last;
  logic signed [17:0] diff;
  logic [16:0]        clamped;

  assign in_ready_int = !rst && ((state_r == IDLE) || (state_r == LOAD));
  assign accept       = bus.in_valid && in_ready_int;
  assign at_last_slot = (wr_idx == LAST_SLOT);
  assign load_end     = accept && (bus.in_last || at_last_slot);
  assign lat_done     = (lat_cnt == LAT_MAX);
  assign exp_last     = (LEN_W'(exp_idx) == len_r - LEN_W'(1));
  assign rd_last      = (LEN_W'(rd_idx) == len_r - LEN_W'(1));

  // Shifted score for the current element, saturated at -10.0; never positive
  // because max_r bounds every stored score.
  always_comb begin
    diff = $signed({score_r[exp_idx][16], score_r[exp_idx]})
         - $signed({max_r[16], max_r});
    if (diff < CLAMP_MIN) clamped = CLAMP_VAL;
    else                  clamped = diff[16:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    next_state    = state_r;
    bus.in_ready  = in_ready_int;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = res_r[rd_idx];
    exp_x         = 17'h00000;
    busy          = !rst && (state_r != IDLE);
    trunc_err     = trunc_r;
    case (state_r)
      IDLE: begin
        if (accept) next_state = load_end ? EXP : LOAD;
      end
      LOAD: begin
        if (load_end) next_state = EXP;
      end
      EXP: begin
        if (!rst) exp_x = clamped;
        if (lat_done && exp_last) next_state = DRAIN;
      end
      DRAIN: begin
        bus.out_valid = !rst;
        bus.out_last  = !rst && rd_last;
        if (bus.out_ready && rd_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Vector buffer, running max, exp sequencing and result readout
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= '0;
      exp_idx <= '0;
      rd_idx  <= '0;
      lat_cnt <= '0;
      len_r   <= '0;
      max_r   <= '0;
      trunc_r <= 1'b0;
      for (int k = 0; k < N_MAX; k++) begin
        score_r[k] <= '0;
        res_r[k]   <= '0;
      end
    end else begin
      trunc_r <= accept && at_last_slot && !bus.in_last;
      if (accept) begin
        score_r[wr_idx] <= $signed(bus.in_data);
        if ((state_r == IDLE) || ($signed(bus.in_data) > max_r))
          max_r <= $signed(bus.in_data);
        if (load_end) begin
          len_r   <= LEN_W'(wr_idx) + LEN_W'(1);
          wr_idx  <= '0;
          exp_idx <= '0;
          lat_cnt <= '0;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
      if (state_r == EXP) begin
        if (lat_done) begin
          res_r[exp_idx] <= exp_y;
          lat_cnt        <= '0;
          exp_idx        <= exp_last ? '0 : exp_idx + IDX_W'(1);
        end else begin
          lat_cnt <= lat_cnt + CNT_W'(1);
        end
      end
      if ((state_r == DRAIN) && bus.out_ready)
        rd_idx <= rd_last ? '0 : rd_idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_softmax_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_softmax_seq_ctrl
//  Purpose  : Directed self-checking bench for softmax_seq_ctrl. The exp unit
//             is modelled as a one-cycle register returning {4'hA, exp_x}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_softmax_seq_ctrl;

  localparam int N_MAX   = 16;
  localparam int EXP_LAT = 1;
  localparam int HOLD    = EXP_LAT + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] exp_x;
  logic [20:0] exp_y;
  logic        busy;
  logic        trunc_err;

  softmax_seq_ctrl_if bus ();

  softmax_seq_ctrl #(.N_MAX(N_MAX), .EXP_LAT(EXP_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .exp_x     (exp_x),
    .exp_y     (exp_y),
    .busy      (busy),
    .trunc_err (trunc_err)
  );

  // Clock
  always #5 clk = ~clk;

  // Exp unit model: one cycle latency, tagged so results are recognisable
  always @(posedge clk) exp_y <= {4'hA, exp_x};

  int n_chk = 0;
  int n_err = 0;

  logic [16:0] dq  [$];   // scores to send
  logic [16:0] exq [$];   // expected exp_x per element
  bit          rdyq[$];   // out_ready pattern during drain

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat; caller is just after a clock edge
  task automatic send(input logic [16:0] d, input logic l);
    int t = 0;
    check("trunc_idle", 32'(trunc_err), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_vec(input bit mark_last);
    for (int i = 0; i < dq.size(); i++)
      send(dq[i], mark_last && (i == dq.size() - 1));
  endtask

  // Starts on the first EXP cycle; each operand must hold HOLD cycles
  task automatic check_exp();
    for (int i = 0; i < exq.size(); i++) begin
      for (int c = 0; c < HOLD; c++) begin
        check("exp_x", 32'(exp_x), 32'(exq[i]));
        check("busy_exp", 32'(busy), 32'd1);
        if (i == 0 && c == 0) check("in_ready_exp", 32'(bus.in_ready), 32'd0);
        if (i > 0 || c > 0)   check("trunc_low", 32'(trunc_err), 32'd0);
        @(posedge clk); #1;
      end
    end
  endtask

  // Starts on the first DRAIN cycle; checks every cycle, stalls included
  task automatic drain();
    int k = 0;
    int t = 0;
    int n = exq.size();
    check("exp_x_drain", 32'(exp_x), 32'd0);
    check("in_ready_drain", 32'(bus.in_ready), 32'd0);
    while (k < n && t < 200) begin
      bus.out_ready = (t < rdyq.size()) ? rdyq[t] : 1'b1;
      #1;
      check("out_valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        check("out_data", 32'(bus.out_data), 32'({4'hA, exq[k]}));
        check("out_last", 32'(bus.out_last), 32'(k == n - 1));
        if (bus.out_ready) k++;
      end
      @(posedge clk); #1;
      t++;
    end
    if (k < n) check("drain_timeout", 32'(k), 32'(n));
    check("out_valid_after", 32'(bus.out_valid), 32'd0);
    check("in_ready_after", 32'(bus.in_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    rdyq = {};
  endtask

  task automatic run_basic();
    dq  = {17'h01000, 17'h02000, 17'h00000};
    exq = {17'h1F000, 17'h00000, 17'h1E000};
    send_vec(1'b1);
    check_exp();
    drain();
  endtask

  initial begin
    bit seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_exp_x", 32'(exp_x), 32'd0);
    check("rst_trunc", 32'(trunc_err), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_post_rst", 32'(bus.in_ready), 32'd1);

    // Three-element vector, max in the middle
    run_basic();

    // Two elements; -16.0 relative to max saturates at -10.0
    dq  = {17'h08000, 17'h18000};
    exq = {17'h00000, 17'h16000};
    send_vec(1'b1);
    check_exp();
    drain();

    // Downstream stalls 1,0,0,1
    dq   = {17'h1F000, 17'h01800, 17'h1C000};
    exq  = {17'h1D800, 17'h00000, 17'h1A800};
    rdyq = {1'b1, 1'b0, 1'b0, 1'b1};
    send_vec(1'b1);
    check_exp();
    drain();

    // Sixteen beats, no last: truncation; element 5 sits exactly at -10.0
    dq  = {};
    exq = {};
    for (int i = 0; i < N_MAX; i++) begin
      int e;
      dq.push_back(17'(i * 4096));
      e = (i - 15) * 4096;
      if (e < -40960) e = -40960;
      exq.push_back(17'(e));
    end
    send_vec(1'b0);
    check("trunc_pulse", 32'(trunc_err), 32'd1);
    check_exp();
    drain();

    // The beat after a cut vector starts its own single-element vector
    dq  = {17'h05000};
    exq = {17'h00000};
    send_vec(1'b1);
    check_exp();
    drain();

    // Single beat with last set in IDLE
    dq  = {17'h0A000};
    exq = {17'h00000};
    send_vec(1'b1);
    check_exp();
    drain();

    // Reset in the middle of EXP drops the vector
    dq = {17'h01000, 17'h02000, 17'h00000};
    send_vec(1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_exp_x", 32'(exp_x), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mid_rst_quiet", 32'(seen), 32'd0);

    // Next vector after the reset
    run_basic();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Run-away guard
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
